// File: rtl/uart_main_controller.sv
// rtl/uart_main_controller.sv - central control FSM of the UART controller
//
// Purpose:
//   Passes host FIFO traffic to the TX/RX datapaths in MAIN, collects RX and
//   configuration error flags into sticky error bits, and runs the 4-packet
//   configuration handshake either as master (host request) or as slave
//   (remote request). Every handshake packet is acknowledged with ACKN_PKT.
//
// Optional feature macro: CONFIG_TIMEOUT_EN
//   When defined, any WAIT_* state lasting TIMEOUT_CYCLES flags a
//   configuration error and returns to MAIN with config_o unchanged.
//
// Ports:
//   clk_i, rst_n_i            clock, synchronous active-low reset
//   interrupt_ackn_i          clears error_o
//   data_rx_i[7:0]            head byte of the RX FIFO
//   data_tx_i[7:0]            host byte to transmit
//   tx_done_i, req_done_i     transmitter byte / request-break complete
//   frame_error_i, parity_i, overrun_error_i, configuration_error_i
//                             error sources collected in MAIN
//   rx_fifo_empty_i, tx_fifo_empty_i   FIFO status
//   rx_fifo_read_i, tx_fifo_write_i    host FIFO strobes
//   config_req_slv_i, config_req_mst_i remote / host handshake requests
//   std_config_i              master sends the standard config
//   config_i[5:0]             {data_width, parity_mode, stop_bits}
//   data_stream_mode_i, req_ackn_i     host stream mode, remote-request permit
//   STR_en_o                  status-register write enable
//   config_o[5:0]             active configuration
//   config_req_mst_o          transmitter drives the request break
//   data_stream_mode_o        registered stream mode
//   configuration_done_o      one-cycle pulse on handshake completion
//   req_ackn_o                slave handshake accepted
//   rx_fifo_read_o, tx_fifo_write_o, data_tx_o[7:0]  FIFO pop / push / data
//   error_o[3:0]              sticky {config, overrun, frame, parity}

module uart_main_controller #(
   parameter logic [7:0]  ACKN_PKT       = 8'hFF,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       interrupt_ackn_i,
   input  logic [7:0] data_rx_i,
   input  logic [7:0] data_tx_i,
   input  logic       tx_done_i,
   input  logic       req_done_i,
   input  logic       frame_error_i,
   input  logic       parity_i,
   input  logic       overrun_error_i,
   input  logic       configuration_error_i,
   input  logic       rx_fifo_empty_i,
   input  logic       tx_fifo_empty_i,
   input  logic       rx_fifo_read_i,
   input  logic       tx_fifo_write_i,
   input  logic       config_req_slv_i,
   input  logic       config_req_mst_i,
   input  logic       std_config_i,
   input  logic [5:0] config_i,
   input  logic       data_stream_mode_i,
   input  logic       req_ackn_i,
   output logic       STR_en_o,
   output logic [5:0] config_o,
   output logic       config_req_mst_o,
   output logic       data_stream_mode_o,
   output logic       configuration_done_o,
   output logic       req_ackn_o,
   output logic       rx_fifo_read_o,
   output logic       tx_fifo_write_o,
   output logic [7:0] data_tx_o,
   output logic [3:0] error_o
);

   localparam logic [5:0] STD_CONFIG = 6'b11_00_00;

   localparam logic [1:0] ID_DATA_WIDTH  = 2'd0;
   localparam logic [1:0] ID_PARITY_MODE = 2'd1;
   localparam logic [1:0] ID_STOP_BITS   = 2'd2;
   localparam logic [1:0] ID_END_CONFIG  = 2'd3;

`ifdef CONFIG_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

   typedef enum logic [3:0] {
      ST_MAIN,
      ST_REQ_MST,
      ST_WAIT_REQ_ACKN_MST,
      ST_SETUP_MST,
      ST_WAIT_TX_MST,
      ST_WAIT_ACKN_MST,
      ST_WAIT_HOST_SLV,
      ST_SETUP_SLV,
      ST_SEND_ACKN_SLV,
      ST_WAIT_TX_SLV
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  idx_q, idx_d;           // master packet index = packet id
   logic [5:0]  mst_cfg_q, mst_cfg_d;   // config the master is sending
   logic [5:0]  shadow_q, shadow_d;     // config the slave is collecting
   logic        end_q, end_d;           // slave has received END packet
   logic [5:0]  config_q, config_d;
   logic [3:0]  error_q, error_d;
   logic        done_q, done_d;
   logic        dsm_q, dsm_d;
   logic [31:0] tmo_q, tmo_d;

   logic [3:0]  err_set;
   logic        hs_err;
   logic [1:0]  pkt_val;
   logic [7:0]  packet;
   logic [1:0]  rx_id;
   logic [1:0]  rx_val;
   logic        rx_invalid;
   logic        in_wait;

   // Transmit FIFO status is not needed by this FSM; the TX path paces itself
   // through tx_done_i.
   logic        unused_tx_fifo_empty;
   assign unused_tx_fifo_empty = tx_fifo_empty_i;

   // Outgoing master packet: {0000, id, value}; END carries value 00.
   always_comb begin
      pkt_val = 2'b00;
      case (idx_q)
         ID_DATA_WIDTH:  pkt_val = mst_cfg_q[5:4];
         ID_PARITY_MODE: pkt_val = mst_cfg_q[3:2];
         ID_STOP_BITS:   pkt_val = mst_cfg_q[1:0];
         default:        pkt_val = 2'b00;
      endcase
      packet = {4'b0000, idx_q, pkt_val};
   end

   // Incoming slave packet decode; stop-bit value 1x is not a legal setting.
   assign rx_id      = data_rx_i[3:2];
   assign rx_val     = data_rx_i[1:0];
   assign rx_invalid = (|data_rx_i[7:4]) || ((rx_id == ID_STOP_BITS) && rx_val[1]);

   assign in_wait = (state_q == ST_WAIT_REQ_ACKN_MST) || (state_q == ST_WAIT_TX_MST) ||
                    (state_q == ST_WAIT_ACKN_MST)     || (state_q == ST_WAIT_HOST_SLV) ||
                    (state_q == ST_WAIT_TX_SLV);

   always_comb begin
      state_d          = state_q;
      idx_d            = idx_q;
      mst_cfg_d        = mst_cfg_q;
      shadow_d         = shadow_q;
      end_d            = end_q;
      config_d         = config_q;
      done_d           = 1'b0;
      dsm_d            = data_stream_mode_i;
      tmo_d            = 32'd0;
      err_set          = 4'b0000;
      hs_err           = 1'b0;
      rx_fifo_read_o   = 1'b0;
      tx_fifo_write_o  = 1'b0;
      data_tx_o        = 8'h00;
      config_req_mst_o = 1'b0;
      req_ackn_o       = 1'b0;

      case (state_q)
         ST_MAIN: begin
            rx_fifo_read_o  = rx_fifo_read_i & ~rx_fifo_empty_i;
            tx_fifo_write_o = tx_fifo_write_i;
            data_tx_o       = data_tx_i;
            err_set         = {configuration_error_i, overrun_error_i,
                               frame_error_i, parity_i};
            if (config_req_slv_i) begin
               state_d  = ST_WAIT_HOST_SLV;
               shadow_d = config_q;
               end_d    = 1'b0;
            end else if (config_req_mst_i) begin
               state_d   = ST_REQ_MST;
               idx_d     = ID_DATA_WIDTH;
               mst_cfg_d = std_config_i ? STD_CONFIG : config_i;
            end
         end

         ST_REQ_MST: begin
            config_req_mst_o = 1'b1;
            if (req_done_i) begin
               state_d = ST_WAIT_REQ_ACKN_MST;
            end
         end

         ST_WAIT_REQ_ACKN_MST: begin
            if (!rx_fifo_empty_i) begin
               rx_fifo_read_o = 1'b1;
               if (data_rx_i == ACKN_PKT) begin
                  state_d = ST_SETUP_MST;
               end else begin
                  hs_err  = 1'b1;
                  state_d = ST_MAIN;
               end
            end
         end

         ST_SETUP_MST: begin
            tx_fifo_write_o = 1'b1;
            data_tx_o       = packet;
            state_d         = ST_WAIT_TX_MST;
         end

         ST_WAIT_TX_MST: begin
            if (tx_done_i) begin
               state_d = ST_WAIT_ACKN_MST;
            end
         end

         ST_WAIT_ACKN_MST: begin
            if (!rx_fifo_empty_i) begin
               rx_fifo_read_o = 1'b1;
               if (data_rx_i != ACKN_PKT) begin
                  hs_err  = 1'b1;
                  state_d = ST_MAIN;
               end else if (idx_q == ID_END_CONFIG) begin
                  config_d = mst_cfg_q;
                  done_d   = 1'b1;
                  state_d  = ST_MAIN;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  state_d = ST_SETUP_MST;
               end
            end
         end

         ST_WAIT_HOST_SLV: begin
            if (req_ackn_i) begin
               req_ackn_o      = 1'b1;
               tx_fifo_write_o = 1'b1;
               data_tx_o       = ACKN_PKT;
               state_d         = ST_WAIT_TX_SLV;
            end
         end

         ST_SETUP_SLV: begin
            if (!rx_fifo_empty_i) begin
               rx_fifo_read_o = 1'b1;
               if (rx_invalid) begin
                  hs_err  = 1'b1;
                  state_d = ST_MAIN;
               end else begin
                  case (rx_id)
                     ID_DATA_WIDTH:  shadow_d[5:4] = rx_val;
                     ID_PARITY_MODE: shadow_d[3:2] = rx_val;
                     ID_STOP_BITS:   shadow_d[1:0] = rx_val;
                     default:        end_d         = 1'b1;
                  endcase
                  state_d = ST_SEND_ACKN_SLV;
               end
            end
         end

         ST_SEND_ACKN_SLV: begin
            tx_fifo_write_o = 1'b1;
            data_tx_o       = ACKN_PKT;
            state_d         = ST_WAIT_TX_SLV;
         end

         ST_WAIT_TX_SLV: begin
            if (tx_done_i) begin
               if (end_q) begin
                  config_d = shadow_q;
                  done_d   = 1'b1;
                  state_d  = ST_MAIN;
               end else begin
                  state_d = ST_SETUP_SLV;
               end
            end
         end

         default: begin
            state_d = ST_MAIN;
         end
      endcase

      // Wait-state watchdog: only counts while parked in the same WAIT_* state.
      if (TMO_EN && in_wait && (state_d == state_q)) begin
         if (tmo_q == TMO_LAST) begin
            hs_err  = 1'b1;
            state_d = ST_MAIN;
         end else begin
            tmo_d = tmo_q + 32'd1;
         end
      end

      // A new error in the same cycle as the acknowledge keeps its bit set.
      error_d  = (interrupt_ackn_i ? 4'b0000 : error_q) | err_set | {hs_err, 3'b000};
      STR_en_o = (|err_set) | hs_err;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q   <= ST_MAIN;
         idx_q     <= 2'd0;
         mst_cfg_q <= STD_CONFIG;
         shadow_q  <= STD_CONFIG;
         end_q     <= 1'b0;
         config_q  <= STD_CONFIG;
         error_q   <= 4'b0000;
         done_q    <= 1'b0;
         dsm_q     <= 1'b0;
         tmo_q     <= 32'd0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         mst_cfg_q <= mst_cfg_d;
         shadow_q  <= shadow_d;
         end_q     <= end_d;
         config_q  <= config_d;
         error_q   <= error_d;
         done_q    <= done_d;
         dsm_q     <= dsm_d;
         tmo_q     <= tmo_d;
      end
   end

   assign config_o             = config_q;
   assign error_o              = error_q;
   assign configuration_done_o = done_q;
   assign data_stream_mode_o   = dsm_q;

endmodule

// File: tb/tb_uart_main_controller.sv
// tb/tb_uart_main_controller.sv - scoreboard bench for uart_main_controller

module tb_uart_main_controller;

   logic       clk = 1'b0;
   logic       rst_n_i = 1'b0;
   logic       interrupt_ackn_i = 1'b0;
   logic [7:0] data_rx_i = 8'h00;
   logic [7:0] data_tx_i = 8'h00;
   logic       tx_done_i = 1'b0;
   logic       req_done_i = 1'b0;
   logic       frame_error_i = 1'b0;
   logic       parity_i = 1'b0;
   logic       overrun_error_i = 1'b0;
   logic       configuration_error_i = 1'b0;
   logic       rx_fifo_empty_i = 1'b1;
   logic       tx_fifo_empty_i = 1'b1;
   logic       rx_fifo_read_i = 1'b0;
   logic       tx_fifo_write_i = 1'b0;
   logic       config_req_slv_i = 1'b0;
   logic       config_req_mst_i = 1'b0;
   logic       std_config_i = 1'b0;
   logic [5:0] config_i = 6'b000000;
   logic       data_stream_mode_i = 1'b0;
   logic       req_ackn_i = 1'b0;

   logic       STR_en_o;
   logic [5:0] config_o;
   logic       config_req_mst_o;
   logic       data_stream_mode_o;
   logic       configuration_done_o;
   logic       req_ackn_o;
   logic       rx_fifo_read_o;
   logic       tx_fifo_write_o;
   logic [7:0] data_tx_o;
   logic [3:0] error_o;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] exp_tx_q[$];
   logic [5:0] exp_cfg_q[$];

   uart_main_controller dut (
      .clk_i                 (clk),
      .rst_n_i               (rst_n_i),
      .interrupt_ackn_i      (interrupt_ackn_i),
      .data_rx_i             (data_rx_i),
      .data_tx_i             (data_tx_i),
      .tx_done_i             (tx_done_i),
      .req_done_i            (req_done_i),
      .frame_error_i         (frame_error_i),
      .parity_i              (parity_i),
      .overrun_error_i       (overrun_error_i),
      .configuration_error_i (configuration_error_i),
      .rx_fifo_empty_i       (rx_fifo_empty_i),
      .tx_fifo_empty_i       (tx_fifo_empty_i),
      .rx_fifo_read_i        (rx_fifo_read_i),
      .tx_fifo_write_i       (tx_fifo_write_i),
      .config_req_slv_i      (config_req_slv_i),
      .config_req_mst_i      (config_req_mst_i),
      .std_config_i          (std_config_i),
      .config_i              (config_i),
      .data_stream_mode_i    (data_stream_mode_i),
      .req_ackn_i            (req_ackn_i),
      .STR_en_o              (STR_en_o),
      .config_o              (config_o),
      .config_req_mst_o      (config_req_mst_o),
      .data_stream_mode_o    (data_stream_mode_o),
      .configuration_done_o  (configuration_done_o),
      .req_ackn_o            (req_ackn_o),
      .rx_fifo_read_o        (rx_fifo_read_o),
      .tx_fifo_write_o       (tx_fifo_write_o),
      .data_tx_o             (data_tx_o),
      .error_o               (error_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops an expectation whenever the DUT pushes a TX byte or
   // reports a completed handshake.
   always @(negedge clk) begin
      if (rst_n_i) begin
         if (tx_fifo_write_o) begin
            if (exp_tx_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL tx_push: got unexpected byte %h expected none at %0t", data_tx_o, $time);
            end else begin
               check("tx_push_data", {24'h0, data_tx_o}, {24'h0, exp_tx_q.pop_front()});
            end
         end
         if (configuration_done_o) begin
            if (exp_cfg_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL config_done: got unexpected pulse config %b expected none at %0t", config_o, $time);
            end else begin
               check("config_done_value", {26'h0, config_o}, {26'h0, exp_cfg_q.pop_front()});
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic probe();
      #3;
   endtask

   logic [7:0] mst_pkts [4];
   logic [7:0] slv_pkts [4];
   logic       prev_dsm;
   logic [4:0] v;
   logic       exp_rd;

   initial begin
      mst_pkts[0] = 8'h03; mst_pkts[1] = 8'h04; mst_pkts[2] = 8'h08; mst_pkts[3] = 8'h0C;
      slv_pkts[0] = 8'h01; slv_pkts[1] = 8'h05; slv_pkts[2] = 8'h09; slv_pkts[3] = 8'h0C;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      rst_n_i = 1'b1;
      probe();
      check("rst_config",     {26'h0, config_o}, 32'h30);
      check("rst_error",      {28'h0, error_o}, 32'h0);
      check("rst_req_mst",    {31'h0, config_req_mst_o}, 32'h0);
      check("rst_done",       {31'h0, configuration_done_o}, 32'h0);
      check("rst_dsm",        {31'h0, data_stream_mode_o}, 32'h0);
      check("rst_tx_write",   {31'h0, tx_fifo_write_o}, 32'h0);

      // MAIN pass-through over a directed pattern of strobes
      prev_dsm = 1'b0;
      for (int i = 0; i < 25; i++) begin
         step();
         v = 5'(i);
         rx_fifo_read_i     = v[0];
         rx_fifo_empty_i    = v[1];
         tx_fifo_write_i    = v[2] | (v == 5'd24);
         data_tx_i          = (v[2] || v == 5'd24) ? 8'h5A : 8'h5A + 8'(i);
         data_stream_mode_i = v[3];
         if (tx_fifo_write_i) exp_tx_q.push_back(data_tx_i);
         exp_rd = v[0] & ~v[1];
         probe();
         check("main_rx_read", {31'h0, rx_fifo_read_o}, {31'h0, exp_rd});
         check("main_dsm",     {31'h0, data_stream_mode_o}, {31'h0, prev_dsm});
         prev_dsm = v[3];
      end
      step();
      rx_fifo_read_i = 1'b0; rx_fifo_empty_i = 1'b1; tx_fifo_write_i = 1'b0;
      data_tx_i = 8'h00; data_stream_mode_i = 1'b0;

      // Sticky error collection and acknowledge
      step(); frame_error_i = 1'b1;
      probe(); check("frame_str_en", {31'h0, STR_en_o}, 32'h1);
      step(); frame_error_i = 1'b0; interrupt_ackn_i = 1'b1;
      probe(); check("frame_error_set", {28'h0, error_o}, 32'h2);
      check("str_en_idle", {31'h0, STR_en_o}, 32'h0);
      step(); interrupt_ackn_i = 1'b0;
      probe(); check("error_cleared", {28'h0, error_o}, 32'h0);
      step(); overrun_error_i = 1'b1;
      step(); overrun_error_i = 1'b0; parity_i = 1'b1; interrupt_ackn_i = 1'b1;
      probe(); check("overrun_set", {28'h0, error_o}, 32'h4);
      step(); parity_i = 1'b0; interrupt_ackn_i = 1'b0;
      probe(); check("ackn_vs_new_error", {28'h0, error_o}, 32'h1);
      step(); interrupt_ackn_i = 1'b1;
      step(); interrupt_ackn_i = 1'b0;
      probe(); check("error_cleared2", {28'h0, error_o}, 32'h0);

      // Master handshake with the standard config
      step(); config_i = 6'b010101; std_config_i = 1'b1; config_req_mst_i = 1'b1;
      data_stream_mode_i = 1'b1;
      step(); config_req_mst_i = 1'b0; std_config_i = 1'b0;
      probe(); check("mst_req_held", {31'h0, config_req_mst_o}, 32'h1);
      step(); req_done_i = 1'b1;
      probe(); check("mst_req_held2", {31'h0, config_req_mst_o}, 32'h1);
      step(); req_done_i = 1'b0; rx_fifo_empty_i = 1'b0; data_rx_i = 8'hFF;
      probe(); check("mst_req_dropped", {31'h0, config_req_mst_o}, 32'h0);
      check("mst_ackn_pop", {31'h0, rx_fifo_read_o}, 32'h1);
      for (int k = 0; k < 4; k++) begin
         step(); rx_fifo_empty_i = 1'b1; exp_tx_q.push_back(mst_pkts[k]);
         step(); tx_done_i = 1'b1;
         step(); tx_done_i = 1'b0; rx_fifo_empty_i = 1'b0; data_rx_i = 8'hFF;
         if (k == 3) exp_cfg_q.push_back(6'b110000);
      end
      step(); rx_fifo_empty_i = 1'b1;
      step();
      probe(); check("mst_config", {26'h0, config_o}, 32'h30);
      check("mst_no_error", {28'h0, error_o}, 32'h0);

      // Slave handshake
      step(); config_req_slv_i = 1'b1;
      step(); config_req_slv_i = 1'b0; req_ackn_i = 1'b1; exp_tx_q.push_back(8'hFF);
      probe(); check("slv_req_ackn", {31'h0, req_ackn_o}, 32'h1);
      step(); req_ackn_i = 1'b0; tx_done_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step(); tx_done_i = 1'b0; rx_fifo_empty_i = 1'b0; data_rx_i = slv_pkts[k];
         probe(); check("slv_pop", {31'h0, rx_fifo_read_o}, 32'h1);
         step(); rx_fifo_empty_i = 1'b1; exp_tx_q.push_back(8'hFF);
         step(); tx_done_i = 1'b1;
         if (k == 3) exp_cfg_q.push_back(6'b010101);
      end
      step(); tx_done_i = 1'b0;
      step();
      probe(); check("slv_config", {26'h0, config_o}, 32'h15);

      // Master receives a non-ACKN byte after its request
      step(); config_i = 6'b000000; config_req_mst_i = 1'b1;
      step(); config_req_mst_i = 1'b0;
      step(); req_done_i = 1'b1;
      step(); req_done_i = 1'b0; rx_fifo_empty_i = 1'b0; data_rx_i = 8'h00;
      probe(); check("bad_ackn_str_en", {31'h0, STR_en_o}, 32'h1);
      step(); rx_fifo_empty_i = 1'b1;
      probe(); check("bad_ackn_error", {28'h0, error_o}, 32'h8);
      check("bad_ackn_config", {26'h0, config_o}, 32'h15);
      step(); tx_fifo_write_i = 1'b1; data_tx_i = 8'h3C; exp_tx_q.push_back(8'h3C);
      step(); tx_fifo_write_i = 1'b0; data_tx_i = 8'h00;

      // Reset while waiting in WAIT_TX_MST
      step(); config_i = 6'b101001; config_req_mst_i = 1'b1;
      step(); config_req_mst_i = 1'b0; req_done_i = 1'b1;
      step(); req_done_i = 1'b0; rx_fifo_empty_i = 1'b0; data_rx_i = 8'hFF;
      step(); rx_fifo_empty_i = 1'b1; exp_tx_q.push_back(8'h02);
      step();
      probe(); check("wait_tx_no_push", {31'h0, tx_fifo_write_o}, 32'h0);
      rst_n_i = 1'b0;
      step();
      probe();
      check("mid_rst_config",  {26'h0, config_o}, 32'h30);
      check("mid_rst_error",   {28'h0, error_o}, 32'h0);
      check("mid_rst_dsm",     {31'h0, data_stream_mode_o}, 32'h0);
      check("mid_rst_req_mst", {31'h0, config_req_mst_o}, 32'h0);
      check("mid_rst_tx_data", {24'h0, data_tx_o}, 32'h0);
      check("mid_rst_done",    {31'h0, configuration_done_o}, 32'h0);
      rst_n_i = 1'b1; data_stream_mode_i = 1'b0;
      step(); tx_fifo_write_i = 1'b1; data_tx_i = 8'h77; exp_tx_q.push_back(8'h77);
      step(); tx_fifo_write_i = 1'b0; data_tx_i = 8'h00;
      step();

      check("tx_queue_drained",  exp_tx_q.size(), 32'h0);
      check("cfg_queue_drained", exp_cfg_q.size(), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_main_controller.md
Name: uart_main_controller

Overview:
- Central control FSM of the UART controller. Sits between the host/register interface and the TX/RX datapaths and FIFOs.
- In MAIN state it passes host FIFO traffic through to the datapaths and collects error flags into sticky error bits.
- Runs a 4-packet configuration handshake, either as master (local request) or as slave (remote request). Each packet is acknowledged with ACKN_PKT.

Parameters:
- ACKN_PKT, 8'hFF, acknowledgement byte exchanged after every handshake step.
- TIMEOUT_CYCLES, 1000000, wait-state timeout; used only when CONFIG_TIMEOUT_EN is defined.

Ports:
- clk_i  in  1  clock; single clock domain, all logic on rising edge.
- rst_n_i  in  1  reset; synchronous, active-low.
- interrupt_ackn_i  in  1  host acknowledges interrupt; clears error_o.
- data_rx_i  in  8  head byte of the RX FIFO.
- data_tx_i  in  8  host byte to transmit.
- tx_done_i  in  1  transmitter finished the current byte.
- req_done_i  in  1  transmitter finished the config-request line break.
- frame_error_i  in  1  RX frame error.
- parity_i  in  1  RX parity error.
- overrun_error_i  in  1  RX FIFO overrun.
- configuration_error_i  in  1  external config mismatch.
- rx_fifo_empty_i  in  1  RX FIFO empty.
- tx_fifo_empty_i  in  1  TX FIFO empty.
- rx_fifo_read_i  in  1  host read request.
- tx_fifo_write_i  in  1  host write request.
- config_req_slv_i  in  1  receiver detected a remote config request.
- config_req_mst_i  in  1  host requests master configuration.
- std_config_i  in  1  master sends the standard config instead of config_i.
- config_i  in  6  {data_width[5:4], parity_mode[3:2], stop_bits[1:0]}.
- data_stream_mode_i  in  1  host stream-mode select.
- req_ackn_i  in  1  host permits acknowledging a remote request.
- STR_en_o  out  1  status-register write enable.
- config_o  out  6  active configuration.
- config_req_mst_o  out  1  tells transmitter to drive the request break.
- data_stream_mode_o  out  1  registered data_stream_mode_i.
- configuration_done_o  out  1  one-cycle pulse when a handshake completes.
- req_ackn_o  out  1  slave handshake accepted.
- rx_fifo_read_o  out  1  RX FIFO pop.
- tx_fifo_write_o  out  1  TX FIFO push.
- data_tx_o  out  8  byte pushed to the TX FIFO.
- error_o  out  4  sticky {config, overrun, frame, parity}.

Behaviour:
- Encodings:
  - Config packet = {4'b0000, id[3:2], value[1:0]}.
  - ids: DATA_WIDTH=0, PARITY_MODE=1, STOP_BITS=2, END_CONFIGURATION=3.
  - data_width 00..11 = 5..8 bits.
  - parity 00 even, 01 odd, 1x none.
  - stop bits 00 one, 01 two, 1x invalid.
  - Standard config = 6'b11_00_00.
- Reset: state MAIN, config_o = standard config; error_o, all strobes, config_req_mst_o, req_ackn_o and data_stream_mode_o = 0; data_tx_o = 0.
- MAIN:
  - Combinational pass-through: rx_fifo_read_o = rx_fifo_read_i & !rx_fifo_empty_i; tx_fifo_write_o = tx_fifo_write_i; data_tx_o = data_tx_i.
  - Each error input sets its error_o bit on the next edge; STR_en_o pulses in that same cycle.
  - interrupt_ackn_i clears error_o; a simultaneous new error wins (bit stays set).
  - data_stream_mode_o registered from data_stream_mode_i every cycle.
- Master path:
  - MAIN with config_req_mst_i → REQ_MST; config_req_mst_o = 1 until req_done_i.
  - WAIT_REQ_ACKN_MST: on !rx_fifo_empty_i pop the byte.
    - ==ACKN_PKT → SETUP_MST.
    - Otherwise set error_o[3] and go to MAIN.
  - Packet selection: packet index k (0..3) uses id k. Values come from config_i, or from the standard config when std_config_i was sampled at the request; END carries value 00.
  - SETUP_MST: one-cycle tx_fifo_write_o with data_tx_o = packet → WAIT_TX_MST.
  - WAIT_TX_MST: on tx_done_i → WAIT_ACKN_MST.
  - WAIT_ACKN_MST: pop the ACKN byte, then next packet; after END, load config_o, pulse configuration_done_o and go to MAIN.
- Slave path:
  - config_req_slv_i → WAIT_HOST_SLV.
  - On req_ackn_i: req_ackn_o pulses, ACKN_PKT is pushed to TX, go to WAIT_TX_SLV.
  - SETUP_SLV: on !rx_fifo_empty_i pop and decode the byte into a shadow register.
    - Invalid byte (upper nibble ≠ 0, or stop bits 1x) → error_o[3], go to MAIN, config_o unchanged.
  - SEND_ACKN_SLV: push ACKN_PKT → WAIT_TX_SLV.
  - WAIT_TX_SLV: on tx_done_i go to SETUP_SLV; after the END packet instead commit the shadow to config_o, pulse configuration_done_o and go to MAIN.
- Priority in MAIN: config_req_slv_i over config_req_mst_i. Host read/write strobes are ignored (outputs 0) outside MAIN.
- Reset mid-handshake returns to MAIN with the standard config.

Optional Feature:
- CONFIG_TIMEOUT_EN defined: any WAIT_* state lasting TIMEOUT_CYCLES sets error_o[3] and returns to MAIN, leaving config_o unchanged.
- CONFIG_TIMEOUT_EN undefined: WAIT_* states wait indefinitely.

Test Plan:
- Reset then 25 random MAIN cycles: rx_fifo_read_i=1 with FIFO non-empty → rx_fifo_read_o=1; tx_fifo_write_i=1, data_tx_i=8'h5A → tx_fifo_write_o=1, data_tx_o=8'h5A same cycle.
- frame_error_i=1 for one cycle → error_o=4'b0010 and STR_en_o pulse; interrupt_ackn_i → error_o=0.
- Master with std_config_i=1: config_req_mst_o held until req_done_i; after ACKN 8'hFF, data_tx_o sequence 8'h03, 8'h04, 8'h08, 8'h0C, each acked after tx_done_i → configuration_done_o pulse, config_o=6'b110000.
- Slave: config_req_slv_i, req_ackn_i → data_tx_o=8'hFF; receiving 8'h01, 8'h05, 8'h09, 8'h0C, each acked → config_o=6'b010101.
- Master receives 8'h00 instead of ACKN → error_o[3]=1, return to MAIN, config_o unchanged.
- Reset asserted in WAIT_TX_MST → MAIN, all outputs at reset values next cycle.
